// File: rtl/vga_sync_detector.sv
// VGA sync receiver: measures HSYNC/VSYNC timing, locks onto the expected mode and
// regenerates active-video flag plus column/row addresses aligned to the incoming syncs.
module vga_sync_detector #(
  parameter logic [10:0] EXP_H_TOTAL = 11'd1904,
  parameter logic [10:0] EXP_H_SYNC  = 11'd152,
  parameter logic [10:0] EXP_V_TOTAL = 11'd932,
  parameter logic [10:0] EXP_V_SYNC  = 11'd3,
  parameter logic [10:0] H_BACK      = 11'd232,
  parameter logic [10:0] H_ACTIVE    = 11'd1440,
  parameter logic [10:0] V_BACK      = 11'd28,
  parameter logic [10:0] V_ACTIVE    = 11'd900,
  parameter logic [10:0] TOL         = 11'd2,
  parameter logic [3:0]  LOCK_FRAMES = 4'd3
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        HSYNC_Sig,
  input  logic        VSYNC_Sig,
  output logic        Locked,
  output logic        Frame_Start,
  output logic [10:0] H_Total_Meas,
  output logic [10:0] H_Sync_Meas,
  output logic [10:0] V_Total_Meas,
  output logic [10:0] V_Sync_Meas,
  output logic        Ready_Sig,
  output logic [10:0] Column_Addr_Sig,
  output logic [10:0] Row_Addr_Sig
);

  typedef enum logic [1:0] {ST_SEARCH, ST_CHECK, ST_LOCKED} state_t;

  localparam logic [10:0] CNT_MAX = '1;
  localparam logic [10:0] H_START = EXP_H_SYNC + H_BACK;
  localparam logic [10:0] H_END   = H_START + H_ACTIVE - 11'd1;
  localparam logic [10:0] V_START = EXP_V_SYNC + V_BACK;
  localparam logic [10:0] V_END   = V_START + V_ACTIVE - 11'd1;

  state_t      state;
  logic [3:0]  frm_cnt;
  logic        hs_d, vs_d;
  logic [10:0] h_cnt, v_cnt;
  logic        h_valid, v_valid, h_err;

  logic        hs_fall, hs_rise, vs_fall, vs_rise, h_sat, v_sat;
  logic [10:0] h_len, v_len, h_tot_now, h_sync_now;
  logic        line_bad, h_err_now, match, fsm_fail, stay_locked, active;

  function automatic logic in_tol(input logic [10:0] meas, input logic [10:0] expv);
    logic [10:0] diff;
    diff = (meas >= expv) ? meas - expv : expv - meas;
    return (diff <= TOL);
  endfunction

  // match looks at the values this vs_fall edge is about to latch, not the stale registers
  always_comb begin
    hs_fall    = hs_d & ~HSYNC_Sig;
    hs_rise    = ~hs_d & HSYNC_Sig;
    vs_fall    = vs_d & ~VSYNC_Sig;
    vs_rise    = ~vs_d & VSYNC_Sig;
    h_sat      = (h_cnt == CNT_MAX);
    v_sat      = (v_cnt == CNT_MAX);
    h_len      = h_cnt + 11'd1;
    v_len      = v_cnt + 11'd1;
    line_bad   = hs_fall & h_valid & ~in_tol(h_len, EXP_H_TOTAL);
    h_err_now  = h_err | line_bad;
    h_tot_now  = (hs_fall & h_valid) ? h_len : H_Total_Meas;
    h_sync_now = hs_rise ? h_len : H_Sync_Meas;
    match      = v_valid & ~h_err_now
               & in_tol(h_tot_now, EXP_H_TOTAL) & in_tol(h_sync_now, EXP_H_SYNC)
               & in_tol(v_len, EXP_V_TOTAL) & in_tol(V_Sync_Meas, EXP_V_SYNC);
    fsm_fail    = h_sat | v_sat | (vs_fall & ~match);
    stay_locked = (state == ST_LOCKED) & ~fsm_fail;
    active      = stay_locked & (h_cnt >= H_START) & (h_cnt <= H_END)
                & (v_cnt >= V_START) & (v_cnt <= V_END);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d         <= 1'b1;
      vs_d         <= 1'b1;
      h_cnt        <= '0;
      v_cnt        <= '0;
      h_valid      <= 1'b0;
      v_valid      <= 1'b0;
      h_err        <= 1'b0;
      Frame_Start  <= 1'b0;
      H_Total_Meas <= '0;
      H_Sync_Meas  <= '0;
      V_Total_Meas <= '0;
      V_Sync_Meas  <= '0;
    end else begin
      hs_d        <= HSYNC_Sig;
      vs_d        <= VSYNC_Sig;
      Frame_Start <= vs_fall;
      if (hs_fall)
        h_cnt <= '0;
      else if (!h_sat)
        h_cnt <= h_len;
      if (vs_fall)
        v_cnt <= '0;
      else if (hs_fall && !v_sat)
        v_cnt <= v_len;
      if (hs_fall && h_valid) H_Total_Meas <= h_len;
      if (hs_rise)            H_Sync_Meas  <= h_len;
      if (vs_fall && v_valid) V_Total_Meas <= v_len;
      if (vs_rise)            V_Sync_Meas  <= v_len;
      if (vs_fall)
        h_err <= 1'b0;
      else if (line_bad)
        h_err <= 1'b1;
      if (h_sat || v_sat) begin
        h_valid <= 1'b0;
        v_valid <= 1'b0;
      end else begin
        if (hs_fall) h_valid <= 1'b1;
        if (vs_fall) v_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_SEARCH;
      frm_cnt <= '0;
      Locked  <= 1'b0;
    end else if (h_sat || v_sat) begin
      state   <= ST_SEARCH;
      frm_cnt <= '0;
      Locked  <= 1'b0;
    end else if (vs_fall) begin
      case (state)
        ST_SEARCH: begin
          if (match) begin
            state   <= ST_CHECK;
            frm_cnt <= 4'd1;
          end
        end
        ST_CHECK: begin
          if (!match) begin
            state   <= ST_SEARCH;
            frm_cnt <= '0;
          end else begin
            frm_cnt <= frm_cnt + 4'd1;
            if (frm_cnt + 4'd1 >= LOCK_FRAMES) begin
              state  <= ST_LOCKED;
              Locked <= 1'b1;
            end
          end
        end
        default: begin
          if (!match) begin
            state   <= ST_SEARCH;
            frm_cnt <= '0;
            Locked  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      Ready_Sig       <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
    end else begin
      Ready_Sig       <= active;
      Column_Addr_Sig <= active ? h_cnt - H_START : '0;
      Row_Addr_Sig    <= active ? v_cnt - V_START : '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_detector.sv
// Directed bench for vga_sync_detector on a scaled-down mode (40x20 lines, sync 4/2,
// active window cols 10..33, rows 5..16) so several frames fit in a short run.
module tb_vga_sync_detector;

  localparam int HS_W = 4;
  localparam int VS_W = 2;
  localparam int HP   = 40;
  localparam int NL   = 20;

  logic        vga_clk, rst_n, HSYNC_Sig, VSYNC_Sig;
  logic        Locked, Frame_Start, Ready_Sig;
  logic [10:0] H_Total_Meas, H_Sync_Meas, V_Total_Meas, V_Sync_Meas;
  logic [10:0] Column_Addr_Sig, Row_Addr_Sig;

  int n_checks = 0;
  int n_fails  = 0;
  int fs_count = 0;
  int fs0;

  vga_sync_detector #(
    .EXP_H_TOTAL(11'd40), .EXP_H_SYNC(11'd4), .EXP_V_TOTAL(11'd20), .EXP_V_SYNC(11'd2),
    .H_BACK(11'd6), .H_ACTIVE(11'd24), .V_BACK(11'd3), .V_ACTIVE(11'd12),
    .TOL(11'd2), .LOCK_FRAMES(4'd3)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .HSYNC_Sig(HSYNC_Sig), .VSYNC_Sig(VSYNC_Sig),
    .Locked(Locked), .Frame_Start(Frame_Start),
    .H_Total_Meas(H_Total_Meas), .H_Sync_Meas(H_Sync_Meas),
    .V_Total_Meas(V_Total_Meas), .V_Sync_Meas(V_Sync_Meas),
    .Ready_Sig(Ready_Sig), .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  always @(negedge vga_clk) if (Frame_Start === 1'b1) fs_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      HSYNC_Sig = 1'b1;
      VSYNC_Sig = 1'b1;
      tick();
    end
  endtask

  // cycles c0..c1 of line ln; line 0 starts with both syncs falling together
  task automatic drive(input int ln, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      HSYNC_Sig = (c < HS_W) ? 1'b0 : 1'b1;
      VSYNC_Sig = (ln < VS_W) ? 1'b0 : 1'b1;
      tick();
    end
  endtask

  task automatic lines(input int l0, input int l1, input int period);
    for (int l = l0; l <= l1; l++) drive(l, 0, period - 1);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    HSYNC_Sig = 1'b1;
    VSYNC_Sig = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    idle(5);
  endtask

  initial begin
    rst_n     = 1'b0;
    HSYNC_Sig = 1'b1;
    VSYNC_Sig = 1'b1;
    tick();
    tick();
    chk("rst_locked", 32'(Locked), 0);
    chk("rst_fs", 32'(Frame_Start), 0);
    chk("rst_htot", 32'(H_Total_Meas), 0);
    chk("rst_ready", 32'(Ready_Sig), 0);
    rst_n = 1'b1;
    idle(5);

    // frames 1..3 nominal: priming + two matches, still unlocked
    for (int f = 0; f < 3; f++) lines(0, NL - 1, HP);
    chk("pre_lock", 32'(Locked), 0);
    drive(0, 0, 0);
    chk("lock_f4", 32'(Locked), 1);
    chk("fs_pulse", 32'(Frame_Start), 1);
    chk("htot_meas", 32'(H_Total_Meas), 40);
    chk("hsync_meas", 32'(H_Sync_Meas), 4);
    chk("vtot_meas", 32'(V_Total_Meas), 20);
    chk("vsync_meas", 32'(V_Sync_Meas), 2);
    drive(0, 1, 1);
    chk("fs_one_cycle", 32'(Frame_Start), 0);

    // active window edges within locked frame 4
    drive(0, 2, HP - 1);
    lines(1, 4, HP);
    drive(5, 0, 10);
    chk("ready_before_first", 32'(Ready_Sig), 0);
    drive(5, 11, 11);
    chk("ready_first", 32'(Ready_Sig), 1);
    chk("col_first", 32'(Column_Addr_Sig), 0);
    chk("row_first", 32'(Row_Addr_Sig), 0);
    drive(5, 12, HP - 1);
    lines(6, 15, HP);
    drive(16, 0, 34);
    chk("ready_last", 32'(Ready_Sig), 1);
    chk("col_last", 32'(Column_Addr_Sig), 23);
    chk("row_last", 32'(Row_Addr_Sig), 11);
    drive(16, 35, 35);
    chk("ready_after_last", 32'(Ready_Sig), 0);
    chk("col_blank", 32'(Column_Addr_Sig), 0);
    chk("row_blank", 32'(Row_Addr_Sig), 0);
    drive(16, 36, HP - 1);
    drive(17, 0, 20);
    chk("ready_row_past_end", 32'(Ready_Sig), 0);
    drive(17, 21, HP - 1);
    lines(18, NL - 1, HP);

    // frame 5: line 7 is 46 cycles long
    lines(0, 6, HP);
    drive(7, 0, 45);
    drive(8, 0, 0);
    chk("htot_bad_line", 32'(H_Total_Meas), 46);
    chk("locked_during_bad", 32'(Locked), 1);
    drive(8, 1, HP - 1);
    lines(9, NL - 1, HP);
    drive(0, 0, 0);
    chk("unlock_herr", 32'(Locked), 0);
    drive(0, 1, HP - 1);
    lines(1, NL - 1, HP);
    lines(0, NL - 1, HP);
    drive(0, 0, 0);
    chk("relock_f8_not_yet", 32'(Locked), 0);
    drive(0, 1, HP - 1);
    lines(1, NL - 1, HP);
    drive(0, 0, 0);
    chk("relock_f9", 32'(Locked), 1);

    // asynchronous reset in the middle of an active line
    drive(0, 1, HP - 1);
    lines(1, 7, HP);
    drive(8, 0, 20);
    chk("ready_mid", 32'(Ready_Sig), 1);
    chk("col_mid", 32'(Column_Addr_Sig), 9);
    chk("row_mid", 32'(Row_Addr_Sig), 3);
    rst_n = 1'b0;
    #2;
    chk("async_rst_locked", 32'(Locked), 0);
    chk("async_rst_ready", 32'(Ready_Sig), 0);
    chk("async_rst_col", 32'(Column_Addr_Sig), 0);
    chk("async_rst_row", 32'(Row_Addr_Sig), 0);
    chk("async_rst_vtot", 32'(V_Total_Meas), 0);
    rst_n = 1'b1;
    fs0 = fs_count;
    drive(8, 21, HP - 1);
    lines(9, NL - 1, HP);
    chk("no_fs_after_rst", 32'(fs_count - fs0), 0);
    drive(0, 0, 0);
    chk("fs_after_rst", 32'(Frame_Start), 1);
    chk("unlocked_after_rst", 32'(Locked), 0);
    drive(0, 1, HP - 1);
    lines(1, NL - 1, HP);
    for (int f = 0; f < 2; f++) lines(0, NL - 1, HP);
    drive(0, 0, 0);
    chk("relock_after_rst", 32'(Locked), 1);

    // HSYNC stuck low: counter saturates 2047 cycles after the last fall
    drive(0, 1, HP - 1);
    lines(1, 7, HP);
    fs0 = fs_count;
    for (int s = 0; s <= 2047; s++) begin
      HSYNC_Sig = 1'b0;
      VSYNC_Sig = 1'b1;
      tick();
    end
    chk("locked_before_sat", 32'(Locked), 1);
    HSYNC_Sig = 1'b0;
    tick();
    chk("unlock_sat", 32'(Locked), 0);
    chk("ready_sat", 32'(Ready_Sig), 0);
    for (int s = 2049; s < 3000; s++) begin
      HSYNC_Sig = 1'b0;
      VSYNC_Sig = 1'b1;
      tick();
    end
    chk("no_fs_stuck", 32'(fs_count - fs0), 0);

    // period at +TOL still locks
    do_reset();
    for (int f = 0; f < 3; f++) lines(0, NL - 1, 42);
    drive(0, 0, 0);
    chk("lock_p42", 32'(Locked), 1);
    chk("htot_p42", 32'(H_Total_Meas), 42);

    // period at +TOL+1 never locks
    do_reset();
    for (int f = 0; f < 4; f++) lines(0, NL - 1, 43);
    drive(0, 0, 0);
    chk("nolock_p43", 32'(Locked), 0);
    chk("htot_p43", 32'(H_Total_Meas), 43);
    chk("vtot_p43", 32'(V_Total_Meas), 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
